// File: rtl/job_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dispatcher_pkg
// Description : Shared state encoding and default sizing for job_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatcher_pkg;

    // Default operand width, FIFO depth and WAIT timeout
    localparam int c_def_w       = 16;
    localparam int c_def_depth   = 4;
    localparam int c_def_timeout = 64;

    // Dispatcher sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } disp_state_t;

endpackage : dispatcher_pkg
`default_nettype wire

// File: rtl/job_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Interface   : job_dispatcher_if
// Description : Operand stream, controller handshake and status bundle of
//               job_dispatcher. The err signal is only present when
//               JOB_DISPATCHER_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface job_dispatcher_if
    import dispatcher_pkg::*;
#(
    parameter int W     = c_def_w,
    parameter int DEPTH = c_def_depth
);

    logic [W-1:0]                 in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [W-1:0]                 x_out;
    logic                         start;
    logic                         done;
    logic                         res_valid;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
    logic                         err;
`endif

`ifdef JOB_DISPATCHER_TIMEOUT_EN
    // Dispatcher side
    modport master (
        input  in_data, in_valid, done,
        output in_ready, x_out, start, res_valid, busy, count, err
    );
    // Producer / controller side
    modport slave (
        output in_data, in_valid, done,
        input  in_ready, x_out, start, res_valid, busy, count, err
    );
`else
    // Dispatcher side
    modport master (
        input  in_data, in_valid, done,
        output in_ready, x_out, start, res_valid, busy, count
    );
    // Producer / controller side
    modport slave (
        output in_data, in_valid, done,
        input  in_ready, x_out, start, res_valid, busy, count
    );
`endif

endinterface : job_dispatcher_if
`default_nettype wire

// File: rtl/job_dispatcher_fifo.sv
`default_nettype none
// ============================================================================
// Module      : job_fifo
// Description : Small power-of-two operand FIFO with occupancy count.
//               Read data is the current head (first-word fall-through).
// Revision    : 1.0 - initial release
// ============================================================================
module job_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        i_push,
    input  wire logic [W-1:0]                i_push_data,
    input  wire logic                        i_pop,
    output logic      [W-1:0]                o_pop_data,
    output logic      [$clog2(DEPTH+1)-1:0]  o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam int                c_cw       = $clog2(DEPTH+1);
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
    localparam logic [c_cw-1:0]   c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0]   c_cnt_full = c_cw'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    // Requests are qualified here so a stray push when full or pop when
    // empty can never corrupt the pointers.
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_full     = (r_count == c_cnt_full);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : job_fifo
`default_nettype wire

// File: rtl/job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : job_dispatcher
// Description : Buffers operands from a valid/ready stream and launches one
//               controller job per operand (start pulse, wait for done,
//               res_valid pulse). x_out is held stable for the whole job.
// Config      : JOB_DISPATCHER_TIMEOUT_EN - abort a job after TIMEOUT WAIT
//               cycles without done and raise a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module job_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int W       = c_def_w,
    parameter int DEPTH   = c_def_depth,
    parameter int TIMEOUT = c_def_timeout
) (
    input  wire logic         clk,
    input  wire logic         rst,
    job_dispatcher_if.master  bus
);

    localparam int c_count_w = $clog2(DEPTH+1);

    // Reject unusable configurations at elaboration time
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("job_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    disp_state_t            r_state;
    logic [W-1:0]           r_x_out;
    logic                   r_start;
    logic                   r_res_valid;
    logic                   r_busy;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [W-1:0]           w_head;
    logic [c_count_w-1:0]   w_count;

`ifdef JOB_DISPATCHER_TIMEOUT_EN
    localparam int                  c_wcnt_w    = $clog2(TIMEOUT+1);
    localparam logic [c_wcnt_w-1:0] c_wait_last = c_wcnt_w'(TIMEOUT - 1);
    localparam logic [c_wcnt_w-1:0] c_wcnt_one  = c_wcnt_w'(1);

    logic [c_wcnt_w-1:0]    r_wait_cnt;
    logic                   r_err;
`endif

    // Ready depends only on registered occupancy, so a pop in the same
    // cycle never opens the input early.
    assign w_push = bus.in_valid && !w_fifo_full;
    assign w_pop  = (r_state == IDLE) && !w_fifo_empty;

    job_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.in_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign bus.in_ready  = !w_fifo_full;
    assign bus.count     = w_count;
    assign bus.x_out     = r_x_out;
    assign bus.start     = r_start;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = r_busy;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
    assign bus.err       = r_err;
`endif

    // Job sequencer: state, operand register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_x_out     <= '0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_x_out <= w_head;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    // done wins over an expiry landing in the same cycle
                    if (bus.done) begin
                        r_res_valid <= 1'b1;
                        r_state     <= ACK;
                    end
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                    else if (r_wait_cnt == c_wait_last) begin
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wcnt_one;
                    end
`endif
                end
                ACK: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : job_dispatcher
`default_nettype wire

// File: tb/tb_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_job_dispatcher
// Description : Self-checking bench for job_dispatcher. A queue-based
//               transaction model predicts every output each cycle.
//               Define JOB_DISPATCHER_TIMEOUT_EN to also cover the timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_job_dispatcher;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
    localparam bit c_timeout_en = 1'b1;
`else
    localparam bit c_timeout_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    job_dispatcher_if #(.W(W), .DEPTH(DEPTH)) bus ();

    job_dispatcher #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: operand queue plus the job currently in flight
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_cur   = '0;
    bit           m_busy  = 1'b0;
    bit           m_resv  = 1'b0;
    bit           m_err   = 1'b0;
    bit           m_acc   = 1'b0;
    int           m_age   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: sample the applied inputs, advance the model, compare outputs
    task automatic step();
        logic         v;
        logic         dn;
        logic         r;
        logic [W-1:0] d;
        bit           acc;
        bit           launch;
        bit           ack;
        v      = bus.in_valid;
        d      = bus.in_data;
        dn     = bus.done;
        r      = rst;
        launch = 1'b0;
        ack    = 1'b0;
        @(posedge clk);
        #1;
        if (!r) begin
            m_q.delete();
            m_cur  = '0;
            m_busy = 1'b0;
            m_resv = 1'b0;
            m_err  = 1'b0;
            m_acc  = 1'b0;
            m_age  = 0;
        end else begin
            acc = v && (m_q.size() < DEPTH);
            if (m_busy) begin
                // age 0 is the start cycle; done counts only from age 1 on
                if (m_resv) begin
                    m_busy = 1'b0;
                end else if (m_age >= 1 && dn) begin
                    ack = 1'b1;
                end else if (c_timeout_en && m_age >= TIMEOUT) begin
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end
                m_age++;
            end else if (m_q.size() > 0) begin
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
                m_age  = 0;
                launch = 1'b1;
            end
            if (acc) m_q.push_back(d);
            m_acc  = acc;
            m_resv = ack;
        end
        check_val("start",     32'(bus.start),     32'(launch));
        check_val("res_valid", 32'(bus.res_valid), 32'(ack));
        check_val("busy",      32'(bus.busy),      32'(m_busy));
        check_val("count",     32'(bus.count),     32'(m_q.size()));
        check_val("in_ready",  32'(bus.in_ready),  32'(m_q.size() < DEPTH));
        check_val("x_out",     32'(bus.x_out),     32'(m_cur));
`ifdef JOB_DISPATCHER_TIMEOUT_EN
        check_val("err",       32'(bus.err),       32'(m_err));
`endif
    endtask

    // Producer: an un-accepted operand is held; otherwise offer a new one
    task automatic set_in(input bit want);
        if (!(bus.in_valid && !m_acc)) begin
            bus.in_valid = want;
            if (want) bus.in_data = W'($urandom);
        end
    endtask

    // Step until a start pulse is sampled, with a bounded budget
    task automatic wait_start();
        int n = 0;
        while (!bus.start && n < 12) begin
            step();
            n++;
        end
        check_val("start_seen", 32'(bus.start), 32'd1);
    endtask

    // Let queued jobs drain with a randomly responding controller
    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            set_in(1'b0);
            bus.done = ($urandom_range(0, 2) == 0);
            step();
        end
        bus.done = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.done     = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // Spurious done while idle
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();

        // Single operand 0x00A5, done 5 cycles after start, spurious done in LAUNCH
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00A5;
        step();
        bus.in_valid = 1'b0;
        wait_start();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        repeat (4) step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        repeat (3) step();

        // Five operands offered while a job sits in WAIT
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1111;
        step();
        bus.in_valid = 1'b0;
        wait_start();
        step();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1);
            step();
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        drain(60);

        // Push and pop in the same cycle at count 2, across pointer wrap
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h2222;
        step();
        bus.in_valid = 1'b0;
        wait_start();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1);
            step();
        end
        bus.done = 1'b1;
        set_in(1'b1);
        step();
        bus.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1);
            step();
        end
        drain(60);

        // Reset while a job is in WAIT; a late done must not produce a result
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3333;
        step();
        bus.in_valid = 1'b0;
        wait_start();
        step();
        step();
        rst = 1'b0;
        step();
        rst      = 1'b1;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();

        // Controller never answers: timeout abort, or indefinite wait without it
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1);
            step();
        end
        for (int i = 0; i < 150; i++) begin
            set_in(1'b0);
            step();
        end
        drain(60);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            set_in(bit'($urandom_range(0, 1)));
            bus.done = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b1;
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_job_dispatcher
`default_nettype wire
